seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a multi-digit 7-segment display.

---
 rtl/seg7_scan_ctrl_pkg.sv | 38 +++
 rtl/seg7_scan_ctrl_if.sv | 28 ++
 rtl/seg7_scan_ctrl_dec.sv | 35 +++
 rtl/seg7_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_scan_ctrl_pkg
//   Shared definitions for the 7-segment scan controller: FSM state
//   encoding and segment patterns (bit order g f e d c b a, active high).
//   Imported by the decoder and the scan controller top.
package seg7_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Hex letters used by the shared decoder; the scan controller never
  // shows them, but the decoder is a general-purpose block.
  localparam logic [6:0] SEG_HA = 7'h77;
  localparam logic [6:0] SEG_HB = 7'h7C;
  localparam logic [6:0] SEG_HC = 7'h39;
  localparam logic [6:0] SEG_HD = 7'h5E;
  localparam logic [6:0] SEG_HE = 7'h79;
  localparam logic [6:0] SEG_HF = 7'h71;

  function automatic logic is_bcd(input logic [3:0] nib);
    return nib <= 4'd9;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if
//   Bundle between a display host and the scan controller.
//   Host -> controller : enable, dwell_cycles, digits_bcd, dp_mask
//   Controller -> host : seg_out, dp_out, digit_sel, frame_done
//   master = host side, slave = scan controller side.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL_W    = 16
);
  logic                    enable;
  logic [DWELL_W-1:0]      dwell_cycles;
  logic [4*NUM_DIGITS-1:0] digits_bcd;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_done;

  modport master (
    output enable, dwell_cycles, digits_bcd, dp_mask,
    input  seg_out, dp_out, digit_sel, frame_done
  );

  modport slave (
    input  enable, dwell_cycles, digits_bcd, dp_mask,
    output seg_out, dp_out, digit_sel, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl_dec.sv
// seg7_scan_ctrl_dec
//   Combinational hex-to-7-segment decoder.
//   nib_i : 4-bit value
//   seg_o : segments g..a, active high
module seg7_scan_ctrl_dec
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_HA;
      4'hB: seg_o = SEG_HB;
      4'hC: seg_o = SEG_HC;
      4'hD: seg_o = SEG_HD;
      4'hE: seg_o = SEG_HE;
      4'hF: seg_o = SEG_HF;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a NUM_DIGITS 7-segment display.
//   One decoder is shared by all digits; a blank gap of BLANK_CYCLES is
//   inserted between digits to avoid ghosting.
//   Ports:
//     clk   : clock
//     reset : synchronous, active-high reset
//     bus   : seg7_scan_ctrl_if.slave (enable, dwell_cycles, digits_bcd,
//             dp_mask in; seg_out, dp_out, digit_sel, frame_done out)
//   Build option SEG7_LZB_EN: leading-zero blanking of digits above digit 0.
//
//   state    | meaning
//   ST_IDLE  | scan stopped, display dark
//   ST_BLANK | all digits off for BLANK_CYCLES between digits
//   ST_SHOW  | digit idx lit for max(dwell_cycles,1) cycles
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_W      = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int BLK_W = $clog2(BLANK_CYCLES + 1);
  localparam int CNT_W = (DWELL_W > BLK_W) ? DWELL_W : BLK_W;
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  fd_q, fd_d;

  logic [CNT_W-1:0]      dwell_load;
  logic [3:0]            snap_nib;
  logic                  snap_dp;
  logic [6:0]            dec_seg;
  logic [6:0]            valid_seg;
  logic [6:0]            show_seg;

  // Zero dwell runs as a single cycle.
  assign dwell_load = (bus.dwell_cycles == '0) ? '0
                    : CNT_W'(bus.dwell_cycles - DWELL_W'(1));

  // Nibble and decimal point of the digit about to be shown; only
  // consumed on the BLANK->SHOW edge, which makes them the snapshot.
  always_comb begin
    snap_nib = 4'd0;
    snap_dp  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        snap_nib = bus.digits_bcd[4*i +: 4];
        snap_dp  = bus.dp_mask[i];
      end
    end
  end

  seg7_scan_ctrl_dec u_dec (
    .nib_i (snap_nib),
    .seg_o (dec_seg)
  );

  // The shared decoder renders hex letters; non-BCD codes stay dark here.
  assign valid_seg = is_bcd(snap_nib) ? dec_seg : SEG_BLANK;

`ifdef SEG7_LZB_EN
  logic lz_blank;

  // Blank when this digit and all digits above it are zero; digit 0 is
  // never blanked so a value of 0 still shows "0".
  always_comb begin
    lz_blank = (idx_q != '0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx_q) && bus.digits_bcd[4*j +: 4] != 4'd0) begin
        lz_blank = 1'b0;
      end
    end
  end

  assign show_seg = lz_blank ? SEG_BLANK : valid_seg;
`else
  assign show_seg = valid_seg;
`endif

  // Outputs are computed alongside the next state so digit_sel, seg_out
  // and dp_out all switch on the same edge as the state register.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    sel_d   = sel_q;
    fd_d    = 1'b0;

    if (!bus.enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b0;
      sel_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          idx_d   = '0;
          cnt_d   = BLANK_LOAD;
          seg_d   = SEG_BLANK;
          dp_d    = 1'b0;
          sel_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == '0) begin
            state_d = ST_SHOW;
            cnt_d   = dwell_load;
            sel_d   = NUM_DIGITS'(1) << idx_q;
            seg_d   = show_seg;
            dp_d    = snap_dp;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == '0) begin
            state_d = ST_BLANK;
            cnt_d   = BLANK_LOAD;
            seg_d   = SEG_BLANK;
            dp_d    = 1'b0;
            sel_d   = '0;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              fd_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          seg_d   = SEG_BLANK;
          dp_d    = 1'b0;
          sel_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b0;
      sel_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      sel_q   <= sel_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
//   Self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, BLANK_CYCLES=2).
//   The reference model tracks only the cycle count since the scan started
//   and derives digit, phase and frame boundaries arithmetically.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int B  = 2;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int       m_t;
  logic [3:0] e_sel;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_fd;

  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg7_scan_ctrl_if #(.NUM_DIGITS(N), .DWELL_W(DW)) sif ();

  seg7_scan_ctrl #(.NUM_DIGITS(N), .DWELL_W(DW), .BLANK_CYCLES(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ref_seg(input logic [15:0] bcd, input int d);
    logic [15:0] upper;
    logic [3:0]  nib;
    upper = bcd >> (4 * d);
    nib   = upper[3:0];
    if (nib > 4'd9) return 7'h00;
`ifdef SEG7_LZB_EN
    if (d > 0 && upper == 16'h0) return 7'h00;
`endif
    return seg_tab[int'(nib)];
  endfunction

  function automatic string obs_str();
    return $sformatf("got sel=%b seg=%h dp=%b fd=%b want sel=%b seg=%h dp=%b fd=%b",
                     sif.digit_sel, sif.seg_out, sif.dp_out, sif.frame_done,
                     e_sel, e_seg, e_dp, e_fd);
  endfunction

  // Advance one clock and update the expected outputs from the inputs that
  // were present at that edge (inputs only change after this returns).
  task automatic tick();
    int p, ph, d, dw;
    @(posedge clk);
    #1;
    if (reset || !sif.enable) m_t = -1;
    else m_t++;
    e_fd  = 1'b0;
    e_sel = '0;
    if (m_t < 0) begin
      e_seg = 7'h00;
      e_dp  = 1'b0;
    end else begin
      dw = (sif.dwell_cycles == 0) ? 1 : int'(sif.dwell_cycles);
      p  = B + dw;
      ph = m_t % p;
      d  = (m_t / p) % N;
      e_fd = (m_t > 0) && (m_t % (N * p) == 0);
      if (ph < B) begin
        e_seg = 7'h00;
        e_dp  = 1'b0;
      end else begin
        e_sel = 4'(1 << d);
        if (ph == B) begin
          e_seg = ref_seg(sif.digits_bcd, d);
          e_dp  = sif.dp_mask[d];
        end
      end
    end
  endtask

  task automatic go_idle();
    sif.enable = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    sif.enable       = 1'b1;
    sif.dwell_cycles = 16'd3;
    sif.digits_bcd   = 16'h4321;
    sif.dp_mask      = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({sif.digit_sel, sif.seg_out, sif.dp_out, sif.frame_done} !== 13'h0) begin
        errors++;
        $display("FAIL reset cyc %0d: %s", i, obs_str());
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int nfd = 0;
    sif.digits_bcd   = 16'h4321;
    sif.dwell_cycles = 16'd3;
    sif.dp_mask      = 4'($urandom);
    for (int i = 0; i < 45; i++) begin
      tick();
      if (sif.frame_done === 1'b1) nfd++;
      checks++;
      if ({sif.digit_sel, sif.seg_out, sif.dp_out, sif.frame_done} !== {e_sel, e_seg, e_dp, e_fd}) begin
        errors++;
        $display("FAIL basic t=%0d %s", m_t, obs_str());
      end
      if (m_t == 2) begin
        checks++;
        if (sif.seg_out !== 7'h06 || sif.digit_sel !== 4'b0001) begin
          errors++;
          $display("FAIL basic_first_digit got sel=%b seg=%h want sel=0001 seg=06",
                   sif.digit_sel, sif.seg_out);
        end
      end
    end
    checks++;
    if (nfd != 2) begin
      errors++;
      $display("FAIL basic_frame_count got %0d want 2", nfd);
    end
  endtask

  task automatic test_dwell0();
    int nfd = 0;
    go_idle();
    sif.dwell_cycles = 16'd0;
    sif.digits_bcd   = 16'($urandom);
    sif.dp_mask      = 4'($urandom);
    sif.enable       = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sif.frame_done === 1'b1) nfd++;
      checks++;
      if ({sif.digit_sel, sif.seg_out, sif.dp_out, sif.frame_done} !== {e_sel, e_seg, e_dp, e_fd}) begin
        errors++;
        $display("FAIL dwell0 t=%0d %s", m_t, obs_str());
      end
    end
    checks++;
    if (nfd != 2) begin
      errors++;
      $display("FAIL dwell0_frame_count got %0d want 2", nfd);
    end
  endtask

  task automatic test_hex_lzb();
    logic [6:0] seen [0:3];
    logic [6:0] want_hi;
`ifdef SEG7_LZB_EN
    want_hi = 7'h00;
`else
    want_hi = 7'h3F;
`endif
    for (int k = 0; k < 4; k++) seen[k] = 7'h55;
    go_idle();
    sif.dwell_cycles = 16'd2;
    sif.digits_bcd   = 16'h00A7;
    sif.dp_mask      = 4'b0000;
    sif.enable       = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      for (int k = 0; k < 4; k++)
        if (sif.digit_sel === 4'(1 << k)) seen[k] = sif.seg_out;
      checks++;
      if ({sif.digit_sel, sif.seg_out, sif.dp_out, sif.frame_done} !== {e_sel, e_seg, e_dp, e_fd}) begin
        errors++;
        $display("FAIL hex_lzb t=%0d %s", m_t, obs_str());
      end
    end
    checks++;
    if (seen[0] !== 7'h07) begin
      errors++;
      $display("FAIL hex_digit0 got %h want 07", seen[0]);
    end
    checks++;
    if (seen[1] !== 7'h00) begin
      errors++;
      $display("FAIL hex_digit1 got %h want 00", seen[1]);
    end
    checks++;
    if (seen[2] !== want_hi || seen[3] !== want_hi) begin
      errors++;
      $display("FAIL lzb_upper got d2=%h d3=%h want %h", seen[2], seen[3], want_hi);
    end
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 6; r++) begin
      go_idle();
      sif.dwell_cycles = 16'($urandom_range(0, 4));
      sif.digits_bcd   = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      sif.dp_mask      = 4'($urandom);
      sif.enable       = 1'b1;
      len = 2 * N * (B + ((sif.dwell_cycles == 0) ? 1 : int'(sif.dwell_cycles))) + 3;
      for (int i = 0; i < len; i++) begin
        tick();
        checks++;
        if ({sif.digit_sel, sif.seg_out, sif.dp_out, sif.frame_done} !== {e_sel, e_seg, e_dp, e_fd}) begin
          errors++;
          $display("FAIL random run=%0d t=%0d bcd=%h %s", r, m_t, sif.digits_bcd, obs_str());
        end
      end
    end
  endtask

  task automatic test_midchange();
    go_idle();
    sif.dwell_cycles = 16'd4;
    sif.digits_bcd   = 16'h9876;
    sif.dp_mask      = 4'b0101;
    sif.enable       = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({sif.digit_sel, sif.seg_out, sif.dp_out, sif.frame_done} !== {e_sel, e_seg, e_dp, e_fd}) begin
        errors++;
        $display("FAIL midchange t=%0d %s", m_t, obs_str());
      end
      sif.digits_bcd = 16'($urandom);
      sif.dp_mask    = 4'($urandom);
    end
  endtask

  task automatic test_enable_drop();
    bit found = 0;
    go_idle();
    sif.dwell_cycles = 16'd3;
    sif.digits_bcd   = 16'h8765;
    sif.dp_mask      = 4'b0100;
    sif.enable       = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      checks++;
      if ({sif.digit_sel, sif.seg_out, sif.dp_out, sif.frame_done} !== {e_sel, e_seg, e_dp, e_fd}) begin
        errors++;
        $display("FAIL drop_pre t=%0d %s", m_t, obs_str());
      end
      if (e_sel == 4'b0100) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL drop_reach got no digit2 want digit2 within 40 cycles");
    end
    sif.enable = 1'b0;
    tick();
    checks++;
    if ({sif.digit_sel, sif.seg_out, sif.dp_out, sif.frame_done} !== 13'h0) begin
      errors++;
      $display("FAIL drop_dark %s", obs_str());
    end
    tick();
    sif.enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({sif.digit_sel, sif.seg_out, sif.dp_out, sif.frame_done} !== {e_sel, e_seg, e_dp, e_fd}) begin
        errors++;
        $display("FAIL drop_restart t=%0d %s", m_t, obs_str());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    go_idle();
    sif.dwell_cycles = 16'd5;
    sif.digits_bcd   = 16'h1234;
    sif.dp_mask      = 4'b1111;
    sif.enable       = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (e_sel != 4'b0000 && sif.digit_sel !== 4'b0000) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rstmid_reach got no lit digit want lit digit within 20 cycles");
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({sif.digit_sel, sif.seg_out, sif.dp_out, sif.frame_done} !== 13'h0) begin
      errors++;
      $display("FAIL rstmid_dark %s", obs_str());
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({sif.digit_sel, sif.seg_out, sif.dp_out, sif.frame_done} !== {e_sel, e_seg, e_dp, e_fd}) begin
        errors++;
        $display("FAIL rstmid_restart t=%0d %s", m_t, obs_str());
      end
    end
  endtask

  initial begin
    m_t              = -1;
    e_sel            = '0;
    e_seg            = '0;
    e_dp             = 1'b0;
    e_fd             = 1'b0;
    reset            = 1'b1;
    sif.enable       = 1'b0;
    sif.dwell_cycles = '0;
    sif.digits_bcd   = '0;
    sif.dp_mask      = '0;

    test_reset();
    test_basic();
    test_dwell0();
    test_hex_lzb();
    test_random();
    test_midchange();
    test_enable_drop();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
